// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external 64x64 multiplier among NUM_REQ requesters.
// Optional busy-cycle counter enabled by defining MULT_ARB_BUSY_CNT_EN.
module mult_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MULT_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*64-1:0]        req_a,
    input  logic [NUM_REQ*64-1:0]        req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [127:0]                 rsp_prod,
    output logic [63:0]                  mult_a,
    output logic [63:0]                  mult_b,
    input  logic [127:0]                 mult_p
`ifdef MULT_ARB_BUSY_CNT_EN
   ,output logic [31:0]                  busy_cycles
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [3:0] LAT = 4'(MULT_LAT);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
    localparam logic [IDW-1:0] LAST = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                    state;
    logic [IDW-1:0]            rr_ptr;
    logic [3:0]                cnt;
    logic [63:0]               op_a;
    logic [63:0]               op_b;
    logic [NUM_REQ-1:0][63:0]  lane_a;
    logic [NUM_REQ-1:0][63:0]  lane_b;
    logic [IDW-1:0]            grant_idx;
    logic [IDW-1:0]            idx;
    logic                      found;

    assign lane_a = req_a;
    assign lane_b = req_b;

    // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    assign req_ready = (rst_n && state == IDLE && found) ? (ONE << grant_idx) : '0;
    assign mult_a    = op_a;
    assign mult_b    = op_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_prod  <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a   <= lane_a[grant_idx];
                        op_b   <= lane_b[grant_idx];
                        rsp_id <= grant_idx;
                        cnt    <= LAT;
                        rr_ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    // Multiplier has had MULT_LAT cycles on stable operands by now.
                    if (cnt == 4'd1) begin
                        rsp_prod  <= mult_p;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MULT_ARB_BUSY_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cycles <= '0;
        end else if (state != IDLE && busy_cycles != 32'hFFFF_FFFF) begin
            busy_cycles <= busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: expected products queued at grant time, popped on response.
module tb_mult_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int MULT_LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [255:0] req_a = '0;
    logic [255:0] req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [1:0]   rsp_id;
    logic [127:0] rsp_prod;
    logic [63:0]  mult_a;
    logic [63:0]  mult_b;
    logic [127:0] mult_p;
`ifdef MULT_ARB_BUSY_CNT_EN
    logic [31:0]  busy_cycles;
`endif

    typedef struct packed {
        logic [1:0]   id;
        logic [127:0] prod;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_rr = 0;

    mult_arbiter #(.NUM_REQ(NUM_REQ), .MULT_LAT(MULT_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_prod(rsp_prod),
        .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p)
`ifdef MULT_ARB_BUSY_CNT_EN
       ,.busy_cycles(busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Combinational shared multiplier.
    assign mult_p = {64'b0, mult_a} * {64'b0, mult_b};

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id %0d prod %h, want no response", rsp_id, rsp_prod);
            end else begin
                e = exp_q.pop_front();
                if (rsp_id !== e.id || rsp_prod !== e.prod) begin
                    errors++;
                    $display("FAIL rsp_match: got id %0d prod %h, want id %0d prod %h", rsp_id, rsp_prod, e.id, e.prod);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_rsp(output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_rr = 0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        req_valid = 4'hF; req_a = {4{64'h1234}}; req_b = {4{64'h5678}};
        #1;
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_prod !== 128'd0 || rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_regs: got id %0d prod %h want 0", rsp_id, rsp_prod); end
        checks++; if (mult_a !== 64'd0 || mult_b !== 64'd0) begin errors++; $display("FAIL reset_mult_ops: got %h %h want 0", mult_a, mult_b); end
`ifdef MULT_ARB_BUSY_CNT_EN
        checks++; if (busy_cycles !== 32'd0) begin errors++; $display("FAIL reset_busy: got %0d want 0", busy_cycles); end
`endif
        req_valid = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL idle_no_valid: got %b want 0000", req_ready); end
    endtask

    task automatic test_single();
        int n;
        req_a[63:0] = 64'd3; req_b[63:0] = 64'd5; rsp_ready = 1'b1; req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        exp_q.push_back('{id: 2'd0, prod: 128'd15});
        model_rr = 1;
        @(posedge clk); #1 req_valid = '0;
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL single_wait_ready: got %b want 0000", req_ready); end
        wait_rsp(n);
        checks++; if (n !== MULT_LAT + 1) begin errors++; $display("FAIL single_latency: got %0d want %0d", n, MULT_LAT + 1); end
        checks++; if (rsp_prod !== 128'd15 || rsp_id !== 2'd0) begin errors++; $display("FAIL single_prod: got id %0d prod %0d want id 0 prod 15", rsp_id, rsp_prod); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %b want 0", rsp_valid); end
`ifdef MULT_ARB_BUSY_CNT_EN
        checks++; if (busy_cycles !== 32'd3) begin errors++; $display("FAIL busy_count: got %0d want 3", busy_cycles); end
`endif
    endtask

    task automatic test_round_robin();
        int n;
        int exp_g;
        apply_reset();
        for (int k = 0; k < NUM_REQ; k++) begin
            req_a[64*k +: 64] = 64'h1000 + 64'(k);
            req_b[64*k +: 64] = 64'h77 + 64'(3 * k);
        end
        rsp_ready = 1'b1; req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            exp_g = model_rr;
            n = -1;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (req_ready !== 4'b0) begin
                    n = c;
                    break;
                end
            end
            checks++; if (req_ready !== (4'b1 << exp_g)) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, 4'b1 << exp_g); end
            if (i > 0) begin
                checks++; if (n !== MULT_LAT + 2) begin errors++; $display("FAIL rr_interval%0d: got %0d want %0d", i, n, MULT_LAT + 2); end
            end
            exp_q.push_back('{id: 2'(exp_g), prod: {64'b0, req_a[64*exp_g +: 64]} * {64'b0, req_b[64*exp_g +: 64]}});
            model_rr = (exp_g + 1) % NUM_REQ;
        end
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(n);
        checks++; if (n !== MULT_LAT + 1) begin errors++; $display("FAIL rr_last_latency: got %0d want %0d", n, MULT_LAT + 1); end
        @(posedge clk); #1;
    endtask

    task automatic test_max_operands();
        int n;
        req_a[255:192] = '1; req_b[255:192] = '1; req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL max_grant: got %b want 1000", req_ready); end
        exp_q.push_back('{id: 2'd3, prod: 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001});
        model_rr = 0;
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(n);
        checks++; if (rsp_prod !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin errors++; $display("FAIL max_prod: got %h want fffffffffffffffe0000000000000001", rsp_prod); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int n;
        logic [63:0]  a1;
        logic [63:0]  b1;
        logic [127:0] p1;
        a1 = 64'hDEAD_BEEF_0000_0011; b1 = 64'h0000_0001_2345_6789;
        p1 = {64'b0, a1} * {64'b0, b1};
        req_a[127:64] = a1; req_b[127:64] = b1;
        req_a[191:128] = 64'd21; req_b[191:128] = 64'd2;
        rsp_ready = 1'b0; req_valid = 4'b0110;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_grant: got %b want 0010", req_ready); end
        exp_q.push_back('{id: 2'd1, prod: p1});
        model_rr = 2;
        @(posedge clk); #1 req_valid = 4'b0100;
        wait_rsp(n);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_prod, mult_a, mult_b, req_ready} !== {1'b1, 2'd1, p1, a1, b1, 4'b0}) begin
                errors++;
                $display("FAIL stall_hold%0d: got v %b id %0d prod %h a %h b %h rdy %b want v 1 id 1 prod %h a %h b %h rdy 0000",
                         c, rsp_valid, rsp_id, rsp_prod, mult_a, mult_b, req_ready, p1, a1, b1);
            end
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL no_grant_on_rsp: got %b want 0000", req_ready); end
        @(posedge clk); #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL stall_next_grant: got %b want 0100", req_ready); end
        exp_q.push_back('{id: 2'd2, prod: 128'd42});
        model_rr = 3;
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(n);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int n;
        req_a[191:128] = 64'd7; req_b[191:128] = 64'd9; req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL abort_grant: got %b want 0100", req_ready); end
        @(posedge clk); #1 req_valid = '0;
        rst_n = 1'b0;
        #1;
        checks++; if ({rsp_valid, mult_a, mult_b, req_ready} !== {1'b0, 64'd0, 64'd0, 4'b0}) begin
            errors++; $display("FAIL abort_in_reset: got v %b a %h b %h rdy %b want all zero", rsp_valid, mult_a, mult_b, req_ready);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        model_rr = 0;
        req_a[63:0] = 64'd11; req_b[63:0] = 64'd13; req_valid = 4'b0101;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL abort_next_grant: got %b want 0001", req_ready); end
        exp_q.push_back('{id: 2'd0, prod: 128'd143});
        model_rr = 1;
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(n);
        checks++; if (n !== MULT_LAT + 1 || rsp_id !== 2'd0) begin errors++; $display("FAIL abort_resp: got lat %0d id %0d want lat %0d id 0", n, rsp_id, MULT_LAT + 1); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_max_operands();
        test_stall();
        test_reset_abort();
        repeat (3) @(posedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL provide parameter NUM_REQ, default 4, number of requesters, legal 2..8.
REQ-002 SHALL provide parameter MULT_LAT, default 2, cycles allowed for the shared multiplier to settle, legal 1..15.
REQ-003 SHALL provide clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL provide rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL provide req_valid  input  NUM_REQ  per-requester operand-valid.
REQ-006 SHALL provide req_ready  output  NUM_REQ  per-requester grant, at most one bit set.
REQ-007 SHALL provide req_a, req_b  input  NUM_REQ*64 each  packed unsigned operands, requester k in bits [64k+63:64k].
REQ-008 SHALL provide rsp_valid  output  1  product available.
REQ-009 SHALL provide rsp_ready  input  1  consumer accepts product.
REQ-010 SHALL provide rsp_id  output  clog2(NUM_REQ)  index of requester owning the product.
REQ-011 SHALL provide rsp_prod  output  128  registered unsigned product.
REQ-012 SHALL provide mult_a, mult_b  output  64 each  operands to the shared 64x64 multiplier.
REQ-013 SHALL provide mult_p  input  128  product returned by the shared multiplier.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; one transaction in flight.
REQ-015 In IDLE, SHALL grant the first asserted req_valid bit at or after rr_ptr, searching upward with wrap from NUM_REQ-1 to 0; req_ready[g] asserted combinationally in that cycle.
REQ-016 On handshake (req_valid[g] & req_ready[g]) SHALL latch req_a/req_b slice g into operand regs, g into rsp_id, load counter with MULT_LAT, set rr_ptr to (g+1) mod NUM_REQ, enter WAIT.
REQ-017 req_ready SHALL be all-zero in WAIT and RESP, and in IDLE when no req_valid set.
REQ-018 mult_a/mult_b SHALL be driven from operand regs only and held stable through WAIT and RESP.
REQ-019 In WAIT counter SHALL decrement each cycle; in the cycle counter equals 1, SHALL capture mult_p into rsp_prod and enter RESP.
REQ-020 Latency: handshake at edge T -> rsp_valid high from edge T+MULT_LAT onward, i.e. first valid cycle MULT_LAT+1 cycles after the grant cycle.
REQ-021 In RESP rsp_valid SHALL be 1 and rsp_prod/rsp_id held stable until rsp_ready=1; on that edge return to IDLE, rsp_valid falls.
REQ-022 No grant SHALL occur in the rsp_valid & rsp_ready cycle; minimum issue interval MULT_LAT+2 cycles.
REQ-023 Requester deasserting req_valid before grant SHALL be legal; no grant and no state change result.
REQ-024 Product SHALL be full 128-bit unsigned A*B; no truncation, no overflow flag.

Reset
REQ-025 rst_n low SHALL asynchronously force: state IDLE, rr_ptr 0, counter 0, operand regs 0 (mult_a=mult_b=0), rsp_prod 0, rsp_id 0, rsp_valid 0, req_ready 0.
REQ-026 Reset during WAIT or RESP SHALL discard the transaction; no response is issued after release.
REQ-027 After release, first arbitration SHALL start from requester 0.

Configuration
REQ-028 With MULT_ARB_BUSY_CNT_EN defined, SHALL add output busy_cycles (32 bits) counting cycles with state != IDLE, saturating at 0xFFFFFFFF, reset to 0.
REQ-029 Without MULT_ARB_BUSY_CNT_EN, busy_cycles port and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 Req 0 only, a=3, b=5, MULT_LAT=2, rsp_ready=1 -> req_ready[0] same cycle, rsp_valid 3 cycles after grant cycle, rsp_prod=15, rsp_id=0.
REQ-031 All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; each rsp_id matches.
REQ-032 a=b=0xFFFF_FFFF_FFFF_FFFF -> rsp_prod=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
REQ-033 rsp_ready low 5 cycles in RESP -> rsp_valid, rsp_prod, rsp_id, mult_a/b stable; req_ready all zero throughout.
REQ-034 rst_n pulsed low in WAIT with req 2 granted, req 0 and 2 valid after release -> no response for the aborted op, next grant to req 0.
REQ-035 MULT_ARB_BUSY_CNT_EN defined, one op, MULT_LAT=2, rsp_ready=1 -> busy_cycles=3.
